// File: rtl/i2c_passthru_infilter_mc.sv
// Multi-channel I2C line filter: optional 2-flop synchroniser, asymmetric up/down
// debounce counter per channel, edge pulses and saturating glitch statistics.
module i2c_passthru_infilter_mc #(
   parameter int unsigned NUM_CH           = 2,
   parameter int unsigned EN_2FF_SYNC      = 1,
   parameter int unsigned CNT_WIDTH        = 4,
   parameter logic [NUM_CH*CNT_WIDTH-1:0] HI2LO_CLKS = {4'd4, 4'd6},
   parameter logic [NUM_CH*CNT_WIDTH-1:0] LO2HI_CLKS = {4'd8, 4'd6},
   parameter logic        RESET_VAL        = 1'b1,
   parameter int unsigned GLITCH_CNT_WIDTH = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic [NUM_CH-1:0]                  i_in,
   input  logic                               i_glitch_clr,
   output logic [NUM_CH-1:0]                  o_out,
   output logic [NUM_CH-1:0]                  o_rise,
   output logic [NUM_CH-1:0]                  o_fall,
   output logic [NUM_CH-1:0]                  o_glitch,
   output logic [NUM_CH*GLITCH_CNT_WIDTH-1:0] o_glitch_cnt
);

   logic [NUM_CH-1:0] s;

   generate
      if (EN_2FF_SYNC != 0) begin : g_sync
         logic [NUM_CH-1:0] sync1;
         logic [NUM_CH-1:0] sync2;

         // Sync flops idle at the bus level so reset release is quiet
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               sync1 <= {NUM_CH{RESET_VAL}};
               sync2 <= {NUM_CH{RESET_VAL}};
            end else begin
               sync1 <= i_in;
               sync2 <= sync1;
            end
         end
         assign s = sync2;
      end else begin : g_nosync
         assign s = i_in;
      end
   endgenerate

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [CNT_WIDTH-1:0]        cnt;
      logic [CNT_WIDTH-1:0]        cnt_nxt;
      logic [CNT_WIDTH-1:0]        thr;
      logic [GLITCH_CNT_WIDTH-1:0] gcnt;
      logic                        out_q;
      logic                        rise_q;
      logic                        fall_q;
      logic                        glitch_q;
      logic                        toggle_c;
      logic                        glitch_c;

      // Count toward the active threshold while the line differs, bleed off otherwise
      always_comb begin
         thr      = out_q ? HI2LO_CLKS[ch*CNT_WIDTH +: CNT_WIDTH]
                          : LO2HI_CLKS[ch*CNT_WIDTH +: CNT_WIDTH];
         cnt_nxt  = cnt;
         toggle_c = 1'b0;
         glitch_c = 1'b0;
         if (s[ch] != out_q) begin
            if (cnt == thr) begin
               cnt_nxt  = '0;
               toggle_c = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_WIDTH'(1);
            end
         end else if (cnt != '0) begin
            cnt_nxt  = cnt - CNT_WIDTH'(1);
            glitch_c = (cnt == CNT_WIDTH'(1));
         end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            cnt      <= '0;
            out_q    <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
         end else begin
            cnt      <= cnt_nxt;
            out_q    <= out_q ^ toggle_c;
            rise_q   <= toggle_c & ~out_q;
            fall_q   <= toggle_c & out_q;
            glitch_q <= glitch_c;
         end
      end

      // Clear wins over a coincident increment; count sticks at all-ones
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            gcnt <= '0;
         end else if (i_glitch_clr) begin
            gcnt <= '0;
         end else if (glitch_c && (gcnt != '1)) begin
            gcnt <= gcnt + GLITCH_CNT_WIDTH'(1);
         end
      end

      assign o_out[ch]    = out_q;
      assign o_rise[ch]   = rise_q;
      assign o_fall[ch]   = fall_q;
      assign o_glitch[ch] = glitch_q;
      assign o_glitch_cnt[ch*GLITCH_CNT_WIDTH +: GLITCH_CNT_WIDTH] = gcnt;
   end

endmodule

// File: doc/i2c_passthru_infilter_mc.md
I2C_PASSTHRU_INFILTER_MC -- requirements
Module: i2c_passthru_infilter_mc

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 2: number of independent filter channels (>=1; channel 0 = SDA, channel 1 = SCL by convention).
REQ-002 The module SHALL have parameter EN_2FF_SYNC, default 1: 1 inserts a 2-flop synchroniser per channel ahead of the filter; 0 feeds the filter directly.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 4: width of each per-channel debounce counter.
REQ-004 The module SHALL have parameter HI2LO_CLKS, default {4'd4,4'd6}: packed NUM_CH*CNT_WIDTH vector; slice [ch*CNT_WIDTH +: CNT_WIDTH] is the high-to-low threshold of channel ch.
REQ-005 The module SHALL have parameter LO2HI_CLKS, default {4'd8,4'd6}: packed per-channel low-to-high thresholds, same layout as HI2LO_CLKS.
REQ-006 The module SHALL have parameter RESET_VAL, default 1: reset level of filtered outputs and synchroniser flops (bus idle).
REQ-007 The module SHALL have parameter GLITCH_CNT_WIDTH, default 8: width of each per-channel glitch counter.
REQ-008 Port i_clk, input, 1: the only clock; all flops sample on its rising edge.
REQ-009 Port i_rst, input, 1: asynchronous, active-high reset.
REQ-010 Port i_in, input, NUM_CH: raw asynchronous line levels.
REQ-011 Port i_glitch_clr, input, 1: synchronous clear of all glitch counters.
REQ-012 Port o_out, output, NUM_CH: filtered line levels.
REQ-013 Port o_rise, output, NUM_CH: one-cycle pulse on the cycle o_out[ch] goes 0->1.
REQ-014 Port o_fall, output, NUM_CH: one-cycle pulse on the cycle o_out[ch] goes 1->0.
REQ-015 Port o_glitch, output, NUM_CH: one-cycle pulse when a pending transition on ch is abandoned.
REQ-016 Port o_glitch_cnt, output, NUM_CH*GLITCH_CNT_WIDTH: packed per-channel saturating glitch counts.

Function
REQ-017 Each channel SHALL be filtered independently; no state is shared between channels except i_glitch_clr.
REQ-018 With EN_2FF_SYNC=1, s[ch] SHALL be i_in[ch] delayed by two i_clk cycles; with EN_2FF_SYNC=0, s[ch] SHALL equal i_in[ch] combinationally.
REQ-019 Per cycle, with T = HI2LO slice when o_out=1 else LO2HI slice, and s!=o_out: if cnt!=T then cnt<=cnt+1, else cnt<=0 and o_out<=~o_out.
REQ-020 Per cycle with s==o_out: cnt SHALL decrement if nonzero, else hold at 0.
REQ-021 Consequence: from cnt=0, a steady differing input SHALL toggle o_out on the clock edge after T+1 consecutive differing samples; T=0 toggles on the first.
REQ-022 o_rise/o_fall SHALL be registered and asserted in the same cycle o_out shows its new value; they SHALL never be asserted together on one channel.
REQ-023 o_glitch[ch] SHALL pulse the cycle after cnt decrements 1->0 with s==o_out; a toggle resetting cnt to 0 SHALL NOT count as a glitch.
REQ-024 On each o_glitch pulse, the channel glitch count SHALL increment, saturating at 2^GLITCH_CNT_WIDTH-1 (no wrap).
REQ-025 i_glitch_clr SHALL zero all glitch counts on the next edge and SHALL take priority over a simultaneous increment; it does not affect cnt, o_out or pulses.
REQ-026 Any threshold slice SHALL be representable in CNT_WIDTH bits; cnt SHALL never exceed the active T.

Reset
REQ-027 While i_rst=1 (asynchronously): o_out and synchroniser flops = {NUM_CH{RESET_VAL}}; cnt, o_rise, o_fall, o_glitch, o_glitch_cnt = 0.
REQ-028 Reset asserted mid-debounce SHALL abandon the pending transition without generating o_glitch or an edge pulse.
REQ-029 After i_rst deasserts with i_in at RESET_VAL, no edge or glitch pulse SHALL occur.

Verification
REQ-030 Defaults, EN_2FF_SYNC=1: i_in[0] 1->0 held -> o_out[0] falls 2+7=9 edges later, o_fall[0] one-cycle pulse coincident.
REQ-031 Defaults: i_in[1] 0->1 held from o_out[1]=0 -> o_out[1] rises after 2+9 edges with o_rise[1]; ch0 unchanged.
REQ-032 i_in[0] low for 3 cycles then high -> o_out[0] stays 1, one o_glitch[0] pulse, glitch count ch0 = 1.
REQ-033 GLITCH_CNT_WIDTH=2, four ch0 glitches -> count saturates at 3; i_glitch_clr in same cycle as a fifth glitch -> count 0.
REQ-034 i_rst pulsed while ch0 cnt=4 mid-fall -> o_out=2'b11, all counts 0, no pulses during or after reset.
REQ-035 Alternating i_in[0] every cycle, threshold 6 -> cnt oscillates 0/1, o_out[0] never toggles, glitch pulses counted.
